// File: rtl/enemy_sprite_renderer.sv
// enemy_sprite_renderer -- walks N_PLANES enemy slots once per frame tick,
// erasing each slot's previously drawn sprite and drawing its new one, and
// emits a registered (x, y, colour, plot) pixel stream for vga_adapter.
// Optional feature: define ENEMY_RENDER_CLIP_EN to suppress plots that fall
// outside the 160x120 screen (or whose coordinate add overflowed) while
// keeping the pixel cycle, so pass timing is identical in both builds.
module enemy_sprite_renderer #(
  parameter int         N_PLANES     = 10,
  parameter int         SPRITE_W     = 4,
  parameter int         SPRITE_H     = 4,
  parameter int         X_W          = 8,
  parameter int         Y_W          = 7,
  parameter logic [2:0] PLANE_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR    = 3'b000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [3:0]              plane_amount,
  input  logic [N_PLANES*X_W-1:0] x_bus,
  input  logic [N_PLANES*Y_W-1:0] y_bus,
  input  logic [N_PLANES-1:0]     vis,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [2:0]              colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int SLOT_W = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;
  localparam int COL_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_PLANES - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(SPRITE_W - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(SPRITE_H - 1);

  typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW, NEXT, DONE} state_t;

  state_t            state, state_nx;
  logic [SLOT_W-1:0] slot, slot_nx;
  logic [COL_W-1:0]  col, col_nx;
  logic [ROW_W-1:0]  row, row_nx;
  logic              pending;

  logic [X_W-1:0]      bus_x  [N_PLANES];
  logic [Y_W-1:0]      bus_y  [N_PLANES];
  logic [X_W-1:0]      cur_x  [N_PLANES];
  logic [Y_W-1:0]      cur_y  [N_PLANES];
  logic [X_W-1:0]      prev_x [N_PLANES];
  logic [Y_W-1:0]      prev_y [N_PLANES];
  logic [N_PLANES-1:0] vis_eff, cur_vis, prev_drawn;

  logic [X_W-1:0] base_x, pix_x, x_nx;
  logic [Y_W-1:0] base_y, pix_y, y_nx;
  logic [2:0]     colour_nx;
  logic           plot_nx, pix_ok;

  // Unpack the coordinate buses and qualify visibility with plane_amount.
  for (genvar i = 0; i < N_PLANES; i++) begin : g_slot
    assign bus_x[i]   = x_bus[i*X_W +: X_W];
    assign bus_y[i]   = y_bus[i*Y_W +: Y_W];
    assign vis_eff[i] = vis[i] & (i < int'(plane_amount));
  end

  // A slot starts with its erase phase, else its draw phase, else just NEXT.
  function automatic state_t slot_entry(input logic drawn, input logic visible);
    if (drawn)   return ERASE;
    if (visible) return DRAW;
    return NEXT;
  endfunction

  // State register and pixel counters.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      slot  <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
      col   <= col_nx;
      row   <= row_nx;
    end
  end

  // Next-state logic: slot walk and row-major pixel counting.
  // NOTE: every output of a combinational block gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    col_nx   = col;
    row_nx   = row;
    unique case (state)
      IDLE:  if (frame_tick || pending) state_nx = LATCH;
      LATCH: begin
        slot_nx  = '0;
        col_nx   = '0;
        row_nx   = '0;
        state_nx = slot_entry(prev_drawn[0], vis_eff[0]);
      end
      ERASE, DRAW: begin
        if (col == LAST_COL) begin
          col_nx = '0;
          if (row == LAST_ROW) begin
            row_nx   = '0;
            state_nx = (state == ERASE && cur_vis[slot]) ? DRAW : NEXT;
          end else begin
            row_nx = row + 1'b1;
          end
        end else begin
          col_nx = col + 1'b1;
        end
      end
      NEXT: begin
        if (slot == LAST_SLOT) begin
          state_nx = DONE;
        end else begin
          slot_nx  = slot + 1'b1;
          state_nx = slot_entry(prev_drawn[slot_nx], cur_vis[slot_nx]);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Base coordinates of the pixel about to be shown; the first draw after
  // LATCH reads the bus directly because the snapshot lands on that edge.
  always_comb begin
    base_x = prev_x[slot_nx];
    base_y = prev_y[slot_nx];
    if (state_nx == DRAW) begin
      base_x = (state == LATCH) ? bus_x[slot_nx] : cur_x[slot_nx];
      base_y = (state == LATCH) ? bus_y[slot_nx] : cur_y[slot_nx];
    end
  end

`ifdef ENEMY_RENDER_CLIP_EN
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  assign sum_x  = {1'b0, base_x} + (X_W+1)'(col_nx);
  assign sum_y  = {1'b0, base_y} + (Y_W+1)'(row_nx);
  assign pix_x  = sum_x[X_W-1:0];
  assign pix_y  = sum_y[Y_W-1:0];
  assign pix_ok = !sum_x[X_W] && !sum_y[Y_W] &&
                  (32'(sum_x) < 32'd160) && (32'(sum_y) < 32'd120);
`else
  assign pix_x  = base_x + X_W'(col_nx);
  assign pix_y  = base_y + Y_W'(row_nx);
  assign pix_ok = 1'b1;
`endif

  // Output decode for the state being entered, so the registered pixel
  // lines up with the cycle its phase is active.
  always_comb begin
    x_nx      = x;
    y_nx      = y;
    colour_nx = colour;
    plot_nx   = 1'b0;
    if (state_nx == ERASE || state_nx == DRAW) begin
      x_nx      = pix_x;
      y_nx      = pix_y;
      colour_nx = (state_nx == DRAW) ? PLANE_COLOUR : BG_COLOUR;
      plot_nx   = pix_ok;
    end
  end

  // Registered pixel stream and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      x          <= x_nx;
      y          <= y_nx;
      colour     <= colour_nx;
      plot       <= plot_nx;
      busy       <= (state_nx != IDLE);
      frame_done <= (state_nx == DONE);
    end
  end

  // One-deep tick queue: a tick during a pass is held; a second one is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE) begin
      pending <= 1'b0;
    end else if (frame_tick) begin
      if (pending) overflow <= 1'b1;
      else         pending  <= 1'b1;
    end
  end

  // Erase tracking: which slots currently have a sprite on screen.
  always_ff @(posedge clk) begin
    if (reset)              prev_drawn       <= '0;
    else if (state == NEXT) prev_drawn[slot] <= cur_vis[slot];
  end

  // Per-frame coordinate snapshot and last-drawn coordinates.
  // NOTE: these arrays are deliberately not reset; every entry is written
  // before it is read (cur_* in LATCH, prev_* gated by prev_drawn).
  always_ff @(posedge clk) begin
    if (state == LATCH) begin
      cur_x   <= bus_x;
      cur_y   <= bus_y;
      cur_vis <= vis_eff;
    end
    if (state == NEXT) begin
      prev_x[slot] <= cur_x[slot];
      prev_y[slot] <= cur_y[slot];
    end
  end

endmodule

// File: tb/tb_enemy_sprite_renderer.sv
// Self-checking bench for enemy_sprite_renderer. A pass-level model turns
// the slot snapshot into the expected per-cycle stream (LATCH, erase/draw
// pixels, NEXT, DONE) and each scenario compares the DUT against it.
module tb_enemy_sprite_renderer;

  localparam int N  = 10;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam logic [2:0] PC = 3'b100;
  localparam logic [2:0] BC = 3'b000;

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_tick;
  logic [3:0]      plane_amount;
  logic [N*XW-1:0] x_bus;
  logic [N*YW-1:0] y_bus;
  logic [N-1:0]    vis;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [2:0]      colour;
  logic            plot, busy, frame_done, overflow;

  always #5 clk = ~clk;

  enemy_sprite_renderer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .plane_amount(plane_amount), .x_bus(x_bus), .y_bus(y_bus), .vis(vis),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .frame_done(frame_done), .overflow(overflow)
  );

  typedef struct {
    bit       plot;
    bit       done;
    int       x;
    int       y;
    bit [2:0] colour;
  } cyc_t;

  cyc_t exp_q[$];
  int   m_prev_x [N];
  int   m_prev_y [N];
  bit   m_drawn  [N];
  bit   m_pending, m_overflow;
  int   checks = 0;
  int   errors = 0;

  function automatic void push_idle(bit done);
    cyc_t e;
    e.plot = 1'b0; e.done = done; e.x = 0; e.y = 0; e.colour = 3'b000;
    exp_q.push_back(e);
  endfunction

  // One sprite: row-major, column fastest, coordinates wrap to bus width.
  function automatic void push_sprite(int bx, int by, bit [2:0] col);
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        cyc_t e;
        int px = bx + c;
        int py = by + r;
`ifdef ENEMY_RENDER_CLIP_EN
        e.plot = (px < 160) && (py < 120);
`else
        e.plot = 1'b1;
`endif
        e.done = 1'b0; e.x = px % 256; e.y = py % 128; e.colour = col;
        exp_q.push_back(e);
      end
    end
  endfunction

  // Expected stream of a whole pass from the inputs present at LATCH.
  function automatic void build_pass();
    exp_q.delete();
    push_idle(1'b0);
    for (int i = 0; i < N; i++) begin
      int cx = int'(x_bus[i*XW +: XW]);
      int cy = int'(y_bus[i*YW +: YW]);
      bit on = vis[i] && (i < int'(plane_amount));
      if (m_drawn[i]) push_sprite(m_prev_x[i], m_prev_y[i], BC);
      if (on)         push_sprite(cx, cy, PC);
      push_idle(1'b0);
      m_prev_x[i] = cx;
      m_prev_y[i] = cy;
      m_drawn[i]  = on;
    end
    push_idle(1'b1);
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      x_bus[i*XW +: XW] = XW'($urandom());
      y_bus[i*YW +: YW] = YW'($urandom());
    end
    vis          = N'($urandom());
    plane_amount = 4'($urandom_range(0, 15));
  endtask

  task automatic set_plane(input int i, input int px, input int py);
    x_bus[i*XW +: XW] = XW'(px);
    y_bus[i*YW +: YW] = YW'(py);
  endtask

  // Single-cycle tick from idle; returns inside the LATCH cycle.
  task automatic kick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  // Walks one pass cycle by cycle starting at its LATCH cycle. Optional
  // extra ticks at offsets tick_a/tick_b, input scrambling after LATCH,
  // and a reset at offset abort_k. again reports a queued follow-on pass.
  task automatic run_pass(input string name, input int tick_a, input int tick_b,
                          input int abort_k, input bit scramble, output bit again);
    again = 1'b0;
    build_pass();
    for (int k = 0; k < exp_q.size(); k++) begin
      cyc_t e = exp_q[k];
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL %s busy k=%0d got %b exp 1", name, k, busy);
      end
      checks++;
      if (plot !== e.plot) begin
        errors++; $display("FAIL %s plot k=%0d got %b exp %b", name, k, plot, e.plot);
      end
      checks++;
      if (frame_done !== e.done) begin
        errors++; $display("FAIL %s frame_done k=%0d got %b exp %b", name, k, frame_done, e.done);
      end
      if (e.plot) begin
        checks++;
        if (x !== XW'(e.x) || y !== YW'(e.y) || colour !== e.colour) begin
          errors++;
          $display("FAIL %s pixel k=%0d got (%0d,%0d,%b) exp (%0d,%0d,%b)",
                   name, k, x, y, colour, e.x, e.y, e.colour);
        end
      end
      if (scramble && k == 2) randomize_inputs();
      if (k == abort_k) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL %s abort got plot=%b busy=%b done=%b ovf=%b exp all 0",
                   name, plot, busy, frame_done, overflow);
        end
        for (int i = 0; i < N; i++) m_drawn[i] = 1'b0;
        m_pending  = 1'b0;
        m_overflow = 1'b0;
        return;
      end
      frame_tick = (k == tick_a) || (k == tick_b);
      if (frame_tick) begin
        if (m_pending) m_overflow = 1'b1;
        else           m_pending  = 1'b1;
      end
    end
    @(negedge clk);
    frame_tick = 1'b0;
    checks++;
    if (busy !== 1'b0 || plot !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got busy=%b plot=%b done=%b exp 0", name, busy, plot, frame_done);
    end
    checks++;
    if (overflow !== m_overflow) begin
      errors++; $display("FAIL %s overflow got %b exp %b", name, overflow, m_overflow);
    end
    again     = m_pending;
    m_pending = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; plane_amount = '0;
    x_bus = '0; y_bus = '0; vis = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({x, y, colour, plot, busy, frame_done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset got x=%0d y=%0d c=%b plot=%b busy=%b done=%b ovf=%b exp all 0",
               x, y, colour, plot, busy, frame_done, overflow);
    end
    reset = 1'b0;
    for (int i = 0; i < N; i++) m_drawn[i] = 1'b0;
    m_pending = 1'b0; m_overflow = 1'b0;
  endtask

  task automatic test_single_plane();
    bit again;
    randomize_inputs();
    vis = N'(1); plane_amount = 4'd1;
    set_plane(0, 10, 20);
    kick();
    run_pass("single", -1, -1, -1, 1'b0, again);
  endtask

  task automatic test_move();
    bit again;
    set_plane(0, 11, 20);
    kick();
    run_pass("move", -1, -1, -1, 1'b0, again);
  endtask

  task automatic test_plane_amount();
    bit again;
    for (int p = 0; p < 2; p++) begin
      randomize_inputs();
      vis = '1; plane_amount = 4'd3;
      kick();
      run_pass("amount", -1, -1, -1, 1'b0, again);
    end
  endtask

  task automatic test_back_to_back();
    bit again;
    randomize_inputs();
    plane_amount = 4'd4; vis = '1;
    kick();
    run_pass("b2b_first", 5, 9, -1, 1'b0, again);
    if (again) run_pass("b2b_second", -1, -1, -1, 1'b0, again);
    kick();
    run_pass("b2b_sticky", -1, -1, -1, 1'b0, again);
  endtask

  task automatic test_edge_clip();
    bit again;
    randomize_inputs();
    vis = N'(1); plane_amount = 4'd1;
    set_plane(0, 158, 118);
    kick();
    run_pass("edge", -1, -1, -1, 1'b0, again);
  endtask

  task automatic test_random();
    bit again;
    for (int p = 0; p < 6; p++) begin
      int ta = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : -1;
      randomize_inputs();
      kick();
      run_pass("random", ta, -1, -1, 1'b1, again);
      while (again) run_pass("random_queued", -1, -1, -1, 1'b1, again);
    end
  endtask

  task automatic test_reset_mid_pass();
    bit again;
    randomize_inputs();
    vis = N'(1); plane_amount = 4'd1;
    set_plane(0, 40, 50);
    kick();
    run_pass("pre_abort", -1, -1, -1, 1'b0, again);
    // Slot 0 erases at offsets 1..16 and draws from 17; 21 is its 5th draw pixel.
    kick();
    run_pass("abort", -1, -1, 21, 1'b0, again);
    kick();
    run_pass("post_abort", -1, -1, -1, 1'b0, again);
  endtask

  initial begin
    test_reset();
    test_single_plane();
    test_move();
    test_plane_amount();
    test_back_to_back();
    test_edge_clip();
    test_random();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
